ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
// EX->MEM pipeline stage: sits directly downstream of the ALU.
// Captures ALU result, zero flag and memory/writeback control into a 2-entry skid buffer.
// Valid/ready handshake on both sides; only state drives in_ready, with no comb path from out_ready.
// Resolves conditional branches (branch & zero) and emits a registered redirect to fetch.
// PARAMETERS
// DATA_WIDTH  32  width of ALU result, store data, branch target
// REG_ADDR_W  5   width of destination register index
// PORTS
// clk             in   1           rising-edge clock
// rst_n           in   1           async active-low reset
// in_valid        in   1           EX presents a valid entry
// in_ready        out  1           stage can accept an entry
// alu_result_i    in   DATA_WIDTH  ALU_result from the ALU
// zero_i          in   1           zero flag from the ALU
// store_data_i    in   DATA_WIDTH  rs2 data for stores
// rd_i            in   REG_ADDR_W  destination register
// reg_write_i     in   1           writeback enable
// mem_read_i      in   1           load
// mem_write_i     in   1           store
// branch_i        in   1           conditional branch (ALU op was SUB 4'b0110)
// branch_target_i in   DATA_WIDTH  branch target PC
// flush           in   1           discard all held entries and the current input
// out_valid       out  1           entry valid toward MEM
// out_ready       in   1           MEM accepts the entry
// alu_result_o    out  DATA_WIDTH  registered ALU result (memory address / wb data)
// zero_o          out  1           registered zero flag
// store_data_o    out  DATA_WIDTH  registered store data
// rd_o            out  REG_ADDR_W  registered destination register
// reg_write_o     out  1           registered writeback enable
// mem_read_o      out  1           registered load enable
// mem_write_o     out  1           registered store enable
// branch_taken_o  out  1           1-cycle redirect pulse
// branch_target_o out  DATA_WIDTH  target qualified by branch_taken_o
// BEHAVIOUR
// - push = in_valid & in_ready & !flush.
// - pop = out_valid & out_ready.
// - Entry fields: {alu_result, zero, store_data, rd, reg_write, mem_read, mem_write}.
// - If mem_read_i & mem_write_i are both 1: store with mem_read=0 (store wins).
// - Entry registers: MAIN (drives *_o) and SKID. FSM states:
//   EMPTY: out_valid=0, in_ready=1.
//   HALF:  out_valid=1, in_ready=1.
//   FULL:  out_valid=1, in_ready=0.
// - EMPTY: push -> HALF, MAIN<=in.
// - HALF: push&!pop -> FULL, SKID<=in; push&pop -> HALF, MAIN<=in; !push&pop -> EMPTY.
// - FULL: pop -> HALF, MAIN<=SKID; otherwise hold.
// - Hold in every state when neither push nor pop occurs.
// - flush=1: next state EMPTY regardless of push/pop; the entry being offered is dropped.
// - MAIN contents stay unchanged while out_valid & !out_ready (stall-stable).
// - Strict FIFO order. Latency: in-accept edge -> out_valid next cycle. Throughput 1/clk.
// - in_ready and out_valid decode from registered state only.
// - branch_taken_o <= push & branch_i & zero_i.
//   branch_target_o <= branch_target_i when that holds, else holds its value.
//   branch_taken_o is high for exactly 1 cycle and is independent of the buffer state.
//   Upstream handles squash; the stage does not self-flush.
// - Reset (async, any time incl. mid-transfer): state EMPTY, in_ready=1, out_valid=0.
//   All *_o, branch_taken_o and branch_target_o clear to 0. Held entries are lost.
// TESTING
// - Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, all outputs 0 immediately.
// - Pass-through: push alu=0x10,rd=3,rw=1 with out_ready=1 -> next cycle out_valid=1, alu_result_o=0x10, rd_o=3.
// - Backpressure: out_ready=0, push A=1,B=2 -> in_ready=0 after B.
//   Then out_ready=1 -> outputs 1 then 2; in_ready returns to 1.
// - Branch: push branch_i=1, zero_i=1, target=0x80 -> branch_taken_o=1 for 1 cycle, target 0x80.
//   zero_i=0 -> no pulse.
// - Flush: FULL state plus offered entry C, flush=1 -> next cycle out_valid=0 and C is never output.
// - Conflict: mem_read_i=mem_write_i=1 -> mem_write_o=1, mem_read_o=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer for ALU result and memory/writeback
// control, plus a registered branch redirect toward fetch.
//
// state | meaning
// EMPTY | no entry held; out_valid=0, in_ready=1
// HALF  | MAIN holds the head entry; out_valid=1, in_ready=1
// FULL  | MAIN and SKID both hold entries; out_valid=1, in_ready=0
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  zero_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  branch_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result_o,
  output logic                  zero_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  branch_taken_o,
  output logic [DATA_WIDTH-1:0] branch_target_o
);

  localparam int ENTRY_W = 2*DATA_WIDTH + REG_ADDR_W + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   main_q, skid_q, in_entry;
  logic                 push, pop;
  logic                 load_main_in, load_main_skid, load_skid;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  // A load+store conflict resolves to a store.
  assign in_entry = {alu_result_i, zero_i, store_data_i, rd_i, reg_write_i,
                     mem_read_i & ~mem_write_i, mem_write_i};

  assign {alu_result_o, zero_o, store_data_o, rd_o, reg_write_o,
          mem_read_o, mem_write_o} = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_d = HALF;
        HALF: begin
          if (push && !pop)      state_d = FULL;
          else if (!push && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready     = 1'b1;
        load_main_in = push;
      end
      HALF: begin
        in_ready     = 1'b1;
        out_valid    = 1'b1;
        load_main_in = push & pop;
        load_skid    = push & ~pop;
      end
      FULL: begin
        out_valid      = 1'b1;
        load_main_skid = pop;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  // Redirect depends only on the accepted entry, not on buffer occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
    end else begin
      branch_taken_o <= push & branch_i & zero_i;
      if (push && branch_i && zero_i) branch_target_o <= branch_target_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, pass-through, backpressure, branch,
// flush, load/store conflict and FIFO ordering with hand-computed expectations.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result_i, store_data_i, branch_target_i;
  logic        zero_i, reg_write_i, mem_read_i, mem_write_i, branch_i, flush;
  logic [4:0]  rd_i;
  logic        out_valid, out_ready;
  logic [31:0] alu_result_o, store_data_o, branch_target_o;
  logic        zero_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_i(alu_result_i), .zero_i(zero_i), .store_data_i(store_data_i),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_o(alu_result_o), .zero_o(zero_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [4:0] rd);
    in_valid     = 1'b1;
    alu_result_i = alu;
    rd_i         = rd;
    store_data_i = alu + 32'h100;
    reg_write_i  = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; alu_result_i = '0; zero_i = 1'b0; store_data_i = '0;
    rd_i = '0; reg_write_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    branch_i = 1'b0; branch_target_i = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    tick(); tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_alu", alu_result_o, 32'd0);
    rst_n = 1'b1;
    tick();

    // pass-through
    out_ready = 1'b1;
    offer(32'h10, 5'd3);
    tick();
    idle_inputs();
    check_eq("pt_out_valid", 32'(out_valid), 32'd1);
    check_eq("pt_alu", alu_result_o, 32'h10);
    check_eq("pt_rd", 32'(rd_o), 32'd3);
    check_eq("pt_reg_write", 32'(reg_write_o), 32'd1);
    check_eq("pt_store_data", store_data_o, 32'h110);
    tick();
    check_eq("pt_drained", 32'(out_valid), 32'd0);

    // backpressure fills both entries, then drains in order
    out_ready = 1'b0;
    offer(32'h1, 5'd1);
    tick();
    check_eq("bp_half_in_ready", 32'(in_ready), 32'd1);
    offer(32'h2, 5'd2);
    tick();
    idle_inputs();
    check_eq("bp_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_full_alu", alu_result_o, 32'h1);
    tick();
    check_eq("bp_stall_alu", alu_result_o, 32'h1);
    check_eq("bp_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("bp_second_alu", alu_result_o, 32'h2);
    check_eq("bp_second_rd", 32'(rd_o), 32'd2);
    check_eq("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // back-to-back stream at full throughput
    offer(32'h5, 5'd5);
    tick();
    check_eq("tp_first", alu_result_o, 32'h5);
    offer(32'h6, 5'd6);
    tick();
    check_eq("tp_second", alu_result_o, 32'h6);
    offer(32'h7, 5'd7);
    tick();
    idle_inputs();
    check_eq("tp_third", alu_result_o, 32'h7);
    check_eq("tp_third_valid", 32'(out_valid), 32'd1);
    tick();

    // branch taken and not taken
    offer(32'h0, 5'd0);
    branch_i = 1'b1; zero_i = 1'b1; branch_target_i = 32'h80;
    tick();
    idle_inputs();
    check_eq("br_taken", 32'(branch_taken_o), 32'd1);
    check_eq("br_target", branch_target_o, 32'h80);
    check_eq("br_zero_o", 32'(zero_o), 32'd1);
    tick();
    check_eq("br_pulse_end", 32'(branch_taken_o), 32'd0);
    check_eq("br_target_hold", branch_target_o, 32'h80);
    offer(32'h3, 5'd0);
    branch_i = 1'b1; zero_i = 1'b0; branch_target_i = 32'h90;
    tick();
    idle_inputs();
    check_eq("br_nz_no_pulse", 32'(branch_taken_o), 32'd0);
    check_eq("br_nz_target", branch_target_o, 32'h80);
    tick();

    // flush while full with a third entry offered
    out_ready = 1'b0;
    offer(32'hA, 5'd10);
    tick();
    offer(32'hB, 5'd11);
    tick();
    check_eq("fl_full", 32'(in_ready), 32'd0);
    offer(32'hC, 5'd12);
    flush = 1'b1;
    tick();
    idle_inputs();
    check_eq("fl_out_valid", 32'(out_valid), 32'd0);
    check_eq("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("fl_no_c", 32'(out_valid), 32'd0);

    // load/store conflict: store wins
    offer(32'h40, 5'd4);
    mem_read_i = 1'b1; mem_write_i = 1'b1;
    tick();
    idle_inputs();
    check_eq("cf_mem_write", 32'(mem_write_o), 32'd1);
    check_eq("cf_mem_read", 32'(mem_read_o), 32'd0);
    offer(32'h44, 5'd4);
    mem_read_i = 1'b1;
    tick();
    idle_inputs();
    check_eq("ld_mem_read", 32'(mem_read_o), 32'd1);
    check_eq("ld_mem_write", 32'(mem_write_o), 32'd0);
    tick();

    // asynchronous reset mid-transfer
    out_ready = 1'b0;
    offer(32'h55, 5'd9);
    tick();
    offer(32'h66, 5'd8);
    branch_i = 1'b1; zero_i = 1'b1; branch_target_i = 32'hC0;
    tick();
    idle_inputs();
    check_eq("mr_pre_taken", 32'(branch_taken_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_out_valid", 32'(out_valid), 32'd0);
    check_eq("mr_in_ready", 32'(in_ready), 32'd1);
    check_eq("mr_alu", alu_result_o, 32'd0);
    check_eq("mr_rd", 32'(rd_o), 32'd0);
    check_eq("mr_taken", 32'(branch_taken_o), 32'd0);
    check_eq("mr_target", branch_target_o, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("mr_entries_lost", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
